// File: rtl/cfu_pkg.sv
// Shared constants for the requantize/output-packer CFU pair: opcodes,
// packer FSM states and the int8 activation range.
package cfu_pkg;

  localparam logic [6:0] OP_CLEAR  = 7'd0;
  localparam logic [6:0] OP_POP    = 7'd1;
  localparam logic [6:0] OP_FLUSH  = 7'd2;
  localparam logic [6:0] OP_STATUS = 7'd3;

  localparam logic signed [7:0] ACT_MIN = -8'sd128;
  localparam logic signed [7:0] ACT_MAX = 8'sd127;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_POP_WAIT   = 2'd1,
    ST_FLUSH_WAIT = 2'd2,
    ST_RESP       = 2'd3
  } state_e;

  // Lanes at index >= lanes are overwritten with the pad byte.
  function automatic logic [31:0] pad_upper_lanes(input logic [31:0] part,
                                                  input logic [1:0]  lanes,
                                                  input logic [7:0]  pad);
    logic [31:0] w;
    w = part;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i >= 32'(lanes)) w[8*i +: 8] = pad;
    end
    return w;
  endfunction

endpackage

// File: rtl/cfu_word_fifo.sv
// Circular 32-bit word FIFO with synchronous clear and same-cycle push+pop.
module cfu_word_fifo #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [31:0]       wdata_i,
  input  logic              pop_i,
  output logic [31:0]       rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o
);

  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(FIFO_DEPTH);

  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + PTR_ONE;
      if (pop_i)  rptr_d = rptr_q + PTR_ONE;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // When full, push and pop share a slot: the head is read before the edge overwrites it.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cfu_out_packer.sv
// Packs requantized int8 activations four-per-word (little-endian) into a word
// FIFO that the CPU drains through CFU CLEAR/POP/FLUSH/STATUS commands.
module cfu_out_packer
  import cfu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  state_e      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] partial_q, partial_d;
  logic [7:0]  pad_q, pad_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic            fifo_push, fifo_pop, fifo_clr;
  logic [31:0]     fifo_wdata, fifo_rdata;
  logic            fifo_full, fifo_empty;
  logic [ADDR_W:0] fifo_count;

  logic        cmd_fire, in_fire, cmd_blocks_in;
  logic [6:0]  opcode;
  logic [7:0]  pad_in;
  logic [31:0] status_word;
  logic        unused_cmd_bits;

  assign opcode    = cmd_payload_function_id[9:3];
  assign pad_in    = cmd_payload_inputs_0[7:0];
  assign cmd_ready = (state_q == ST_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;

  assign unused_cmd_bits = ^{cmd_payload_inputs_1, cmd_payload_inputs_0[31:8],
                             cmd_payload_function_id[2:0]};

  assign fifo_pop = !fifo_empty &&
                    ((cmd_fire && (opcode == OP_POP)) || (state_q == ST_POP_WAIT));

  // A 4th byte into a full FIFO is only safe when a pop frees the slot on the same edge.
  assign cmd_blocks_in = cmd_fire && ((opcode == OP_CLEAR) || (opcode == OP_FLUSH));
  assign in_ready = (state_q != ST_FLUSH_WAIT) && !cmd_blocks_in &&
                    !((lane_q == 2'd3) && fifo_full && !fifo_pop);
  assign in_fire  = in_valid && in_ready;

  assign status_word = {16'd0, 6'd0, lane_q, {(8-ADDR_W-1){1'b0}}, fifo_count};

  assign rsp_valid             = rsp_valid_q;
  assign rsp_payload_outputs_0 = rsp_data_q;

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    partial_d   = partial_q;
    pad_d       = pad_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    fifo_push   = 1'b0;
    fifo_clr    = 1'b0;
    fifo_wdata  = '0;

    if (in_fire) begin
      if (lane_q == 2'd3) begin
        fifo_push  = 1'b1;
        fifo_wdata = {in_data, partial_q[23:0]};
        lane_d     = '0;
        partial_d  = '0;
      end else begin
        lane_d = lane_q + 2'd1;
        case (lane_q)
          2'd0:    partial_d[7:0]   = in_data;
          2'd1:    partial_d[15:8]  = in_data;
          default: partial_d[23:16] = in_data;
        endcase
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          case (opcode)
            OP_CLEAR: begin
              fifo_clr  = 1'b1;
              lane_d    = '0;
              partial_d = '0;
            end
            OP_POP: begin
              if (!fifo_empty) begin
                rsp_data_d = fifo_rdata;
              end else begin
                state_d     = ST_POP_WAIT;
                rsp_valid_d = 1'b0;
              end
            end
            OP_FLUSH: begin
              if (lane_q != 2'd0) begin
                if (!fifo_full) begin
                  fifo_push  = 1'b1;
                  fifo_wdata = pad_upper_lanes(partial_q, lane_q, pad_in);
                  lane_d     = '0;
                  partial_d  = '0;
                  rsp_data_d = {30'd0, lane_q};
                end else begin
                  pad_d       = pad_in;
                  state_d     = ST_FLUSH_WAIT;
                  rsp_valid_d = 1'b0;
                end
              end
            end
            OP_STATUS: rsp_data_d = status_word;
            default:   rsp_data_d = '0;
          endcase
        end
      end
      ST_POP_WAIT: begin
        if (!fifo_empty) begin
          rsp_data_d  = fifo_rdata;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_FLUSH_WAIT: begin
        if (!fifo_full) begin
          fifo_push   = 1'b1;
          fifo_wdata  = pad_upper_lanes(partial_q, lane_q, pad_q);
          lane_d      = '0;
          partial_d   = '0;
          rsp_data_d  = {30'd0, lane_q};
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      lane_q      <= '0;
      partial_q   <= '0;
      pad_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      partial_q   <= partial_d;
      pad_q       <= pad_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  cfu_word_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clr_i   (fifo_clr),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_cfu_out_packer.sv
// Bench for cfu_out_packer: directed scenarios plus random traffic against a
// byte/word queue model of the packer.
module tb_cfu_out_packer;
  import cfu_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [7:0]  in_data;
  logic        cmd_valid, cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0, cmd_payload_inputs_1;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [7:0]  bq[$];
  logic [31:0] wq[$];

  always #5 clk = ~clk;

  cfu_out_packer #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .in_data                 (in_data),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model_byte(input logic [7:0] b);
    bq.push_back(b);
    if (bq.size() == 4) begin
      wq.push_back({bq[3], bq[2], bq[1], bq[0]});
      bq.delete();
    end
  endfunction

  function automatic logic [31:0] model_flush(input logic [7:0] pad);
    int n = bq.size();
    if (n == 0) return 32'd0;
    repeat (4 - n) model_byte(pad);
    return 32'(n);
  endfunction

  function automatic logic [31:0] model_status();
    return (32'(bq.size()) << 8) | 32'(wq.size());
  endfunction

  function automatic void model_reset();
    bq.delete();
    wq.delete();
  endfunction

  task automatic send_byte(input logic [7:0] b);
    logic done = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) check_eq("in_timeout", 32'(in_ready), 32'd1);
    else model_byte(b);
  endtask

  task automatic issue_cmd(input logic [6:0] op, input logic [31:0] in0);
    logic done = 1'b0;
    cmd_valid               = 1'b1;
    cmd_payload_function_id = {op, 3'($urandom_range(0, 7))};
    cmd_payload_inputs_0    = in0;
    cmd_payload_inputs_1    = $urandom;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    if (!done) check_eq("cmd_timeout", 32'(cmd_ready), 32'd1);
  endtask

  // Response expected on the edge after acceptance; optionally back-pressured.
  task automatic do_cmd(input logic [6:0] op, input logic [31:0] in0, input logic [31:0] exp,
                        input string tag, input int unsigned hold);
    rsp_ready = (hold == 0);
    issue_cmd(op, in0);
    check_eq({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check_eq(tag, rsp_payload_outputs_0, exp);
    repeat (hold) begin
      @(posedge clk); #1;
      check_eq({tag, "_hold"}, rsp_payload_outputs_0, exp);
      check_eq({tag, "_cmdrdy"}, 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp;
    logic [7:0]  pad;
    logic [6:0]  op;
    int unsigned r, sel, byte_w;

    reset = 1'b0; in_valid = 1'b0; in_data = '0; cmd_valid = 1'b0;
    cmd_payload_function_id = '0; cmd_payload_inputs_0 = '0; cmd_payload_inputs_1 = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", rsp_payload_outputs_0, 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: basic pack and pop
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    exp = wq.pop_front();
    do_cmd(OP_POP, 32'd0, exp, "t1_pop", 0);
    do_cmd(OP_STATUS, 32'd0, model_status(), "t1_status", 0);

    // 2: POP waits on an empty FIFO
    issue_cmd(OP_POP, 32'd0);
    check_eq("t2_wait_valid", 32'(rsp_valid), 32'd0);
    send_byte(ACT_MAX);
    send_byte(ACT_MIN);
    send_byte(8'hFF);
    check_eq("t2_wait_valid3", 32'(rsp_valid), 32'd0);
    send_byte(8'h00);
    check_eq("t2_same_edge", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    exp = wq.pop_front();
    check_eq("t2_late_valid", 32'(rsp_valid), 32'd1);
    check_eq("t2_late_data", rsp_payload_outputs_0, exp);
    @(posedge clk); #1;

    // 3: partial flush with -128 pad
    send_byte(8'h11);
    send_byte(8'h22);
    exp = model_flush(8'h80);
    do_cmd(OP_FLUSH, 32'h0000_0080, exp, "t3_flush", 0);
    exp = wq.pop_front();
    do_cmd(OP_POP, 32'd0, exp, "t3_pop", 0);
    do_cmd(OP_FLUSH, 32'h0000_0055, model_flush(8'h55), "t3_flush_empty", 0);

    // 4: fill FIFO, back-pressure on 4th byte, pop and push on the same edge
    for (int i = 1; i <= 32; i++) send_byte(8'(i));
    send_byte(8'h21); send_byte(8'h22); send_byte(8'h23);
    do_cmd(OP_STATUS, 32'd0, model_status(), "t4_status_full", 0);
    in_valid = 1'b1; in_data = 8'h24;
    @(negedge clk);
    check_eq("t4_in_ready_full", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_payload_function_id = {OP_POP, 3'd0};
    @(negedge clk);
    check_eq("t4_in_ready_pop", 32'(in_ready), 32'd1);
    check_eq("t4_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; cmd_valid = 1'b0;
    exp = wq.pop_front();
    model_byte(8'h24);
    check_eq("t4_pop_valid", 32'(rsp_valid), 32'd1);
    check_eq("t4_pop_head", rsp_payload_outputs_0, exp);
    @(posedge clk); #1;
    do_cmd(OP_STATUS, 32'd0, model_status(), "t4_status_after", 0);
    while (wq.size() != 0) begin
      exp = wq.pop_front();
      do_cmd(OP_POP, 32'd0, exp, "t4_drain", 0);
    end

    // 5: held response while bytes keep packing
    for (int i = 0; i < 16; i++) send_byte(8'($urandom));
    rsp_ready = 1'b0;
    exp = wq.pop_front();
    issue_cmd(OP_POP, 32'd0);
    for (int i = 0; i < 5; i++) begin
      send_byte(8'($urandom));
      check_eq("t5_hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("t5_hold_data", rsp_payload_outputs_0, exp);
      check_eq("t5_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("t5_release", 32'(rsp_valid), 32'd0);
    do_cmd(OP_STATUS, 32'd0, model_status(), "t5_status", 0);
    do_cmd(OP_CLEAR, 32'd0, 32'd0, "t5_clear", 0);
    model_reset();
    do_cmd(OP_STATUS, 32'd0, model_status(), "t5_status_clr", 0);

    // FLUSH into a full FIFO stalls
    for (int i = 0; i < 33; i++) send_byte(8'($urandom));
    issue_cmd(OP_FLUSH, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0; #2; reset = 1'b1;
    model_reset();
    @(posedge clk); #1;

    // 6: reset in POP_WAIT with two lanes filled
    send_byte(8'hA1); send_byte(8'hA2);
    do_cmd(OP_STATUS, 32'd0, model_status(), "t6_status_pre", 0);
    issue_cmd(OP_POP, 32'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check_eq("t6_rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("t6_rst_data", rsp_payload_outputs_0, 32'd0);
    check_eq("t6_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    do_cmd(OP_STATUS, 32'd0, model_status(), "t6_status_post", 0);
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i));
    exp = wq.pop_front();
    do_cmd(OP_POP, 32'd0, exp, "t6_fresh_word", 0);

    // random traffic: byte-heavy first half, command-heavy second half
    for (int unsigned n = 0; n < 400; n++) begin
      byte_w = (n < 200) ? 15 : 7;
      r = $urandom_range(0, 19);
      if (r < byte_w) begin
        if (bq.size() == 3 && wq.size() == DEPTH) begin
          in_valid = 1'b1; in_data = 8'($urandom);
          @(negedge clk);
          check_eq("rnd_in_block", 32'(in_ready), 32'd0);
          @(posedge clk); #1;
          in_valid = 1'b0;
        end else begin
          send_byte(8'($urandom));
        end
      end else begin
        sel = $urandom_range(0, 9);
        if (sel < 5) begin
          if (wq.size() != 0) begin
            exp = wq.pop_front();
            do_cmd(OP_POP, $urandom, exp, "rnd_pop", $urandom_range(0, 2));
          end
        end else if (sel < 7) begin
          if (!(wq.size() == DEPTH && bq.size() != 0)) begin
            pad = 8'($urandom);
            exp = model_flush(pad);
            do_cmd(OP_FLUSH, {24'($urandom), pad}, exp, "rnd_flush", 0);
          end
        end else if (sel == 7) begin
          op = 7'($urandom_range(4, 127));
          do_cmd(op, $urandom, 32'd0, "rnd_other", 0);
        end else if (sel == 8 && $urandom_range(0, 3) == 0) begin
          do_cmd(OP_CLEAR, $urandom, 32'd0, "rnd_clear", 0);
          model_reset();
        end else begin
          do_cmd(OP_STATUS, $urandom, model_status(), "rnd_status", 0);
        end
      end
    end

    if (!(wq.size() == DEPTH && bq.size() != 0)) begin
      exp = model_flush(8'h00);
      do_cmd(OP_FLUSH, 32'd0, exp, "end_flush", 0);
    end
    while (wq.size() != 0) begin
      exp = wq.pop_front();
      do_cmd(OP_POP, 32'd0, exp, "end_drain", 0);
    end
    do_cmd(OP_STATUS, 32'd0, model_status(), "end_status", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
